// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, FSM states and score table for line_clearer
package tetris_pkg;

  localparam int ROWS_DEF = 23;
  localparam int COLS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [15:0] SCORE_L0 = 16'd0;
  localparam logic [15:0] SCORE_L1 = 16'd40;
  localparam logic [15:0] SCORE_L2 = 16'd100;
  localparam logic [15:0] SCORE_L3 = 16'd300;
  localparam logic [15:0] SCORE_L4 = 16'd1200;

  // Points for one operation; four or more lines all score as a four-line clear.
  function automatic logic [15:0] line_score(input logic [2:0] n);
    case (n)
      3'd0:    line_score = SCORE_L0;
      3'd1:    line_score = SCORE_L1;
      3'd2:    line_score = SCORE_L2;
      3'd3:    line_score = SCORE_L3;
      default: line_score = SCORE_L4;
    endcase
  endfunction

endpackage

// File: rtl/row_collapse.sv
// rtl/row_collapse.sv - removes one row from the board and drops everything above it by one row
module row_collapse
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic [ROWS*COLS-1:0] board,
  input  logic [RW-1:0]        row_idx,
  output logic [ROWS*COLS-1:0] collapsed
);

  // Rows below row_idx stay, rows at or above it take the row above, the top row fills with zeros.
  always_comb begin
    collapsed = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (i < int'(row_idx)) begin
        collapsed[i*COLS +: COLS] = board[i*COLS +: COLS];
      end else if (i < ROWS - 1) begin
        collapsed[i*COLS +: COLS] = board[(i+1)*COLS +: COLS];
      end
    end
  end

endmodule

// File: rtl/line_clearer.sv
// rtl/line_clearer.sv - scans a captured board one row per cycle, removes full rows, writes the result back
// Optional build macro: LINE_CLEARER_SCORE_EN (score accumulation; score is tied to 0 without it)
module line_clearer
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                 clock_framerate,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic                 busy,
  output logic                 board_we,
  output logic [ROWS*COLS-1:0] board_out,
  output logic                 done,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          score
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t               state_q, state_d;
  logic [ROWS*COLS-1:0] board_q, board_d, board_shifted;
  logic [RW-1:0]        r_q, r_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [COLS-1:0]      cur_row;
  logic                 row_full;
  logic                 finish;

  row_collapse #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_row_collapse (
    .board     (board_q),
    .row_idx   (r_q),
    .collapsed (board_shifted)
  );

  assign cur_row  = board_q[int'(r_q)*COLS +: COLS];
  assign row_full = &cur_row;
  // The scan ends on the cycle the top row is seen non-full; outputs are registered on that edge.
  assign finish   = (state_q == SCAN) && !row_full && (r_q == LAST_ROW);
  assign busy     = (state_q != IDLE);

  // Next-state logic: capture on start, then either collapse the current row or advance past it.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          board_d = board_in;
          r_d     = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          board_d = board_shifted;
          cnt_d   = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
        end else if (r_q == LAST_ROW) begin
          state_d = WRITE;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working board and registered write-back outputs.
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      state_q       <= IDLE;
      board_q       <= '0;
      r_q           <= '0;
      cnt_q         <= '0;
      board_we      <= 1'b0;
      done          <= 1'b0;
      board_out     <= '0;
      lines_cleared <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      board_we <= finish;
      done     <= finish;
      if (finish) begin
        board_out     <= board_q;
        lines_cleared <= cnt_q;
      end
    end
  end

`ifdef LINE_CLEARER_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  // One extra bit catches overflow so the score can pin at its maximum.
  always_comb begin
    score_sum = {1'b0, score_q} + {1'b0, line_score(cnt_q)};
  end

  // Score accumulates once per completed operation.
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      score_q <= '0;
    end else if (finish) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_line_clearer.sv
// tb/tb_line_clearer.sv - scoreboard bench for line_clearer
module tb_line_clearer;

  localparam int ROWS = 23;
  localparam int COLS = 10;
  localparam int W    = ROWS * COLS;

  logic          clock_framerate = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  board_in = '0;
  logic          busy;
  logic          board_we;
  logic [W-1:0]  board_out;
  logic          done;
  logic [2:0]    lines_cleared;
  logic [15:0]   score;

  line_clearer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock_framerate (clock_framerate),
    .resetn          (resetn),
    .start           (start),
    .board_in        (board_in),
    .busy            (busy),
    .board_we        (board_we),
    .board_out       (board_out),
    .done            (done),
    .lines_cleared   (lines_cleared),
    .score           (score)
  );

  always #5 clock_framerate = ~clock_framerate;

  typedef struct {
    logic [W-1:0] board;
    logic [2:0]   lines;
    logic [15:0]  score;
    int           lat;
    int           start_cyc;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   model_score = 0;
  logic [COLS-1:0] FULL_ROW = '1;

  always @(posedge clock_framerate) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] set_row(input logic [W-1:0] b, input int r, input logic [COLS-1:0] v);
    logic [W-1:0] t;
    t = b;
    t[r*COLS +: COLS] = v;
    return t;
  endfunction

  function automatic int points(input int k);
    case (k)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  // Monitor: every write-back strobe must match the oldest outstanding expectation.
  always @(negedge clock_framerate) begin
    if (done || board_we) begin
      check("we_eq_done", 256'(board_we), 256'(done));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=%0b we=%0b expected no write-back", done, board_we);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("lines_%0d", e.id), 256'(lines_cleared), 256'(e.lines));
        check($sformatf("board_%0d", e.id), 256'(board_out), 256'(e.board));
        check($sformatf("score_%0d", e.id), 256'(score), 256'(e.score));
        check($sformatf("latency_%0d", e.id), 256'(cyc - e.start_cyc + 1), 256'(e.lat));
        check($sformatf("busy_at_done_%0d", e.id), 256'(busy), 256'(1));
      end
    end
  end

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clock_framerate);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock_framerate);
    check("busy_idle_after", 256'(busy), 256'(0));
  endtask

  // Issue one operation; optionally pulse start again mid-scan, which must be ignored.
  task automatic run_op(input int id, input logic [W-1:0] b, input logic [W-1:0] exp_b,
                        input int k, input int lat, input int extra_start_at);
    exp_t e;
    @(negedge clock_framerate);
    board_in = b;
    start = 1'b1;
    @(posedge clock_framerate);
    #1;
    start = 1'b0;
    board_in = '1;
    `ifdef LINE_CLEARER_SCORE_EN
    model_score = model_score + points(k);
    if (model_score > 65535) model_score = 65535;
    `else
    model_score = 0;
    `endif
    e.board = exp_b;
    e.lines = (k > 7) ? 3'd7 : 3'(k);
    e.score = 16'(model_score);
    e.lat = lat;
    e.start_cyc = cyc;
    e.id = id;
    exp_q.push_back(e);
    if (extra_start_at > 0) begin
      repeat (extra_start_at) @(negedge clock_framerate);
      board_in = '0;
      start = 1'b1;
      @(negedge clock_framerate);
      start = 1'b0;
    end
    wait_drain(200);
  endtask

  initial begin
    logic [W-1:0] b;
    logic [W-1:0] x;

    repeat (3) @(posedge clock_framerate);
    @(negedge clock_framerate);
    resetn = 1'b1;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_we", 256'(board_we), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_board", 256'(board_out), 256'(0));
    check("rst_lines", 256'(lines_cleared), 256'(0));
    check("rst_score", 256'(score), 256'(0));

    // Empty board.
    run_op(1, '0, '0, 0, 24, 0);

    // Row 0 full, row 1 holds one cell.
    b = set_row('0, 0, FULL_ROW);
    b = set_row(b, 1, 10'b0000000001);
    x = set_row('0, 0, 10'b0000000001);
    run_op(2, b, x, 1, 25, 0);

    // Four full rows under a single cell.
    b = '0;
    for (int i = 0; i < 4; i++) b = set_row(b, i, FULL_ROW);
    b = set_row(b, 4, 10'b1000000000);
    x = set_row('0, 0, 10'b1000000000);
    run_op(3, b, x, 4, 28, 0);

    // Only the top row full.
    b = set_row('0, 22, FULL_ROW);
    run_op(4, b, '0, 1, 25, 0);

    // Adjacent full rows 3 and 4 with content below and above.
    b = set_row('0, 2, 10'h0F0);
    b = set_row(b, 3, FULL_ROW);
    b = set_row(b, 4, FULL_ROW);
    b = set_row(b, 5, 10'h155);
    b = set_row(b, 7, 10'h001);
    x = set_row('0, 2, 10'h0F0);
    x = set_row(x, 3, 10'h155);
    x = set_row(x, 5, 10'h001);
    run_op(5, b, x, 2, 26, 0);

    // Entire board full: counter saturates at 7.
    run_op(6, '1, '0, 23, 47, 0);

    // Second start during scan is ignored.
    b = set_row('0, 0, FULL_ROW);
    b = set_row(b, 1, 10'b0000000001);
    x = set_row('0, 0, 10'b0000000001);
    run_op(7, b, x, 1, 25, 5);
    repeat (40) @(posedge clock_framerate);

    // Reset mid-scan aborts with no write-back and clears the score.
    @(negedge clock_framerate);
    board_in = set_row('0, 0, FULL_ROW);
    start = 1'b1;
    @(negedge clock_framerate);
    start = 1'b0;
    repeat (5) @(negedge clock_framerate);
    check("busy_mid_scan", 256'(busy), 256'(1));
    resetn = 1'b0;
    @(posedge clock_framerate);
    #1;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_we", 256'(board_we), 256'(0));
    model_score = 0;
    @(negedge clock_framerate);
    resetn = 1'b1;
    check("abort_score", 256'(score), 256'(0));
    check("abort_lines", 256'(lines_cleared), 256'(0));
    repeat (60) @(posedge clock_framerate);

    // Normal operation after the abort starts from a cleared score.
    b = set_row('0, 1, FULL_ROW);
    run_op(8, b, '0, 1, 25, 0);

    // Repeated four-line clears drive the score into saturation.
    b = '0;
    for (int i = 0; i < 4; i++) b = set_row(b, i, FULL_ROW);
    b = set_row(b, 4, 10'b1000000000);
    x = set_row('0, 0, 10'b1000000000);
    for (int n = 0; n < 56; n++) run_op(100 + n, b, x, 4, 28, 0);
    `ifdef LINE_CLEARER_SCORE_EN
    check("score_saturated", 256'(score), 256'(16'hFFFF));
    `else
    check("score_disabled", 256'(score), 256'(0));
    `endif

    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_clearer.md
LINE_CLEARER -- requirements
Module: line_clearer

Interface
REQ-001 Parameter ROWS, default 23, number of board rows; row 0 is the bottom row.
REQ-002 Parameter COLS, default 10, number of columns per row.
REQ-003 clock_framerate  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse from the game core: a piece has been written into the board.
REQ-006 board_in  input  ROWS*COLS  flattened board; row r occupies bits [r*COLS +: COLS].
REQ-007 busy  output  1  high from start acceptance until the cycle after done.
REQ-008 board_we  output  1  one-cycle strobe; the game core SHALL load board_out when it is high.
REQ-009 board_out  output  ROWS*COLS  collapsed board, same packing as board_in.
REQ-010 done  output  1  one-cycle pulse, coincident with board_we.
REQ-011 lines_cleared  output  3  number of rows removed by the last operation; held until the next done.
REQ-012 score  output  16  accumulated score.

Function
REQ-013 FSM states: IDLE, SCAN, WRITE.
REQ-014 IDLE + start: capture board_in into the internal board register, set row index r=0, clear the line counter, go to SCAN.
REQ-015 start SHALL be ignored in SCAN and WRITE.
REQ-016 SCAN, one row per cycle:
  - row r all ones: shift rows r+1..ROWS-1 down by one, zero-fill row ROWS-1, increment the line counter, keep r.
  - otherwise: r=r+1.
REQ-017 SCAN exit: after row ROWS-1 is evaluated as not full, go to WRITE. If row ROWS-1 is full, it is cleared and re-evaluated as empty on the next cycle.
REQ-018 WRITE: assert board_we and done for exactly one cycle, drive board_out, update lines_cleared, then go to IDLE.
REQ-019 Latency: with k rows cleared, done is high in cycle N+ROWS+k+1, where the start edge is cycle N. Zero rows cleared gives 24 cycles.
REQ-020 board_out SHALL hold its value outside WRITE. The internal board SHALL NOT track board_in after capture.
REQ-021 The line counter SHALL saturate at 7.
REQ-022 Adjacent full rows (e.g. rows 3 and 4) SHALL both be cleared, because r is re-checked after each shift.
REQ-023 busy SHALL be high in SCAN and WRITE and low in IDLE.

Reset
REQ-024 resetn low at a clock edge: state goes to IDLE and the internal board clears to 0, including during an operation.
REQ-025 Reset values: busy=0, board_we=0, done=0, board_out=0, lines_cleared=0, score=0.
REQ-026 An aborted operation SHALL produce no board_we.

Configuration
REQ-027 Macro LINE_CLEARER_SCORE_EN.
  - Defined: in WRITE, score adds 0/40/100/300/1200 for 0/1/2/3/>=4 lines, saturating at 65535.
  - Undefined: no score logic is built and score is tied to 0.

Structure
REQ-028 Shared package tetris_pkg holds:
  - ROWS/COLS defaults
  - the FSM state enum
  - score-table constants
REQ-029 Sub-module row_collapse: combinational; takes the board and r and returns the shifted board. It is instantiated once.

Verification
REQ-030 Empty board + start -> done at cycle N+24, lines_cleared=0, board_out=0, score unchanged.
REQ-031 Row 0 full, row 1 = 10'b0000000001 -> done at N+25, lines_cleared=1, board_out row 0 = 10'b0000000001, score=40.
REQ-032 Rows 0-3 full, row 4 = 10'b1000000000 -> lines_cleared=4, board_out row 0 = 10'b1000000000, score +1200, done at N+28.
REQ-033 Row 22 full only -> lines_cleared=1, board_out all zero, done at N+25.
REQ-034 Second start pulse during SCAN -> ignored, exactly one done; resetn low mid-SCAN -> busy=0 next cycle, no board_we.
REQ-035 Score preset near 65535 (repeated 4-line clears) -> score saturates at 65535. With LINE_CLEARER_SCORE_EN undefined -> score stays 0.
